crc32_arbiter: RTL and testbench
================================

Name: crc32_arbiter

Overview:
Round-robin arbiter and sequencer that shares one crc32_calculator instance between NUM_REQ independent requesters. Each requester presents a 32-bit word and receives its CRC, plus a per-transaction error flag. The block drives the engine's start/data_valid/data_in handshake, waits for done with a watchdog, and routes the result back to the owning requester. It sits between the requester fabric and a single crc32_calculator.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of grant index (minimum 1)
TIMEOUT_CYCLES, 64, max WAIT_DONE cycles before abort (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester request; held with req_data until its req_ready
req_data  input  NUM_REQ*32  requester i word at bits [32*i+31:32*i]
req_ready  output  NUM_REQ  one-cycle one-hot accept pulse
rsp_valid  output  NUM_REQ  one-cycle one-hot result pulse
rsp_crc  output  32  result CRC, valid when any rsp_valid bit is high
rsp_error  output  1  qualifies rsp_valid: 1 = timeout, rsp_crc = 0
eng_data_in  output  32  to engine data_in
eng_start  output  1  to engine start
eng_data_valid  output  1  to engine data_valid
eng_crc_out  input  32  from engine crc_out
eng_done  input  1  from engine done
eng_ready  input  1  from engine ready
busy  output  1  high whenever state != IDLE
grant_id  output  ID_W  index of current/last granted requester
timeout_flag  output  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- All outputs registered. Reset (async, any time incl. mid-transaction): state=IDLE, all outputs 0, last_grant=NUM_REQ-1 so requester 0 wins first. Abandoned requests get no rsp_valid. The engine shares rst_n.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE: if any req_valid is high and eng_ready=1, select the first set bit scanning from last_grant+1 upward with wrap (modulo NUM_REQ). Latch index into grant_id and the word into an internal register. Go to ISSUE. If eng_ready=0, stay in IDLE; no grant.
- ISSUE (exactly 1 cycle): eng_start=1, eng_data_valid=1, eng_data_in=latched word, req_ready[grant_id]=1. Clear the watchdog counter. Next state is WAIT_DONE. The requester may drop or change req_valid/data from the following cycle.
- WAIT_DONE: eng_start=eng_data_valid=0. eng_data_in holds the latched word. The counter increments each cycle.
  - eng_done=1: capture eng_crc_out into rsp_crc, rsp_error=0, go to RESPOND.
  - Else, counter reaches TIMEOUT_CYCLES-1: rsp_crc=0, rsp_error=1, timeout_flag=1, go to RESPOND.
  - done and the timeout on the same cycle: done wins.
  - eng_done is ignored in every state other than WAIT_DONE.
- RESPOND (exactly 1 cycle): rsp_valid[grant_id]=1. last_grant<=grant_id. Next state is IDLE. rsp_crc and rsp_error hold until the next RESPOND.
- Throughput: minimum 4 cycles per transaction plus engine latency. No back-to-back grant to the same requester while another requester is pending.
- Single requester continuously valid: served every transaction, no starvation logic needed.
- Requests arriving while busy wait; none are lost, provided the requester holds req_valid.
- req_ready and rsp_valid are always one-hot or zero. Any other value is a checkable error.

Test Plan:
- Reset then req_valid=0001 with word 00000000 -> req_ready[0] pulse in ISSUE; eng_start/eng_data_valid high 1 cycle; rsp_valid=0001, rsp_crc=2144DF1C, rsp_error=0; busy falls after RESPOND.
- All four requesting simultaneously (words 00000000, 12345678, DEADBEEF, AAAAAAAA) -> grant order 0,1,2,3. CRCs 2144DF1C, AF6D87D2, 1A5A601F, B596E05E are routed to the matching rsp_valid bit.
- Requesters 1 and 3 held valid continuously with last_grant=1 -> grants alternate 3,1,3,1. Neither is granted twice in a row.
- Engine stub with eng_done stuck 0 -> rsp_valid pulses TIMEOUT_CYCLES cycles after ISSUE, with rsp_error=1, rsp_crc=0, timeout_flag=1. The next request (55555555) completes with CRC 6B2DC0BD and rsp_error=0, while timeout_flag stays 1.
- eng_ready held 0 with req_valid=0010 -> stays IDLE, no req_ready. Raise eng_ready -> grant 1 on the next cycle.
- Assert rst_n=0 during WAIT_DONE -> all outputs 0 immediately (asynchronous) and no rsp_valid. After release, requester 0 is granted first.

Source files
------------

// File: rtl/crc32_arbiter.sv
// Round-robin front end that time-shares one crc32_calculator between NUM_REQ requesters.
// One word per transaction: grant, issue, wait for done (with watchdog), respond.
module crc32_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_crc,
    output logic                    rsp_error,
    output logic [31:0]             eng_data_in,
    output logic                    eng_start,
    output logic                    eng_data_valid,
    input  logic [31:0]             eng_crc_out,
    input  logic                    eng_done,
    input  logic                    eng_ready,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    timeout_flag
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("crc32_arbiter: NUM_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("crc32_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ID_W-1:0]        r_last;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_REQ-1:0]     r_req_ready;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [31:0]            r_rsp_crc;
    logic                   r_rsp_error;
    logic [31:0]            r_word;
    logic                   r_issue;
    logic                   r_busy;
    logic [ID_W-1:0]        r_grant;
    logic                   r_timeout;

    logic                   w_pick_found;
    logic [ID_W-1:0]        w_pick_idx;
    logic [ID_W:0]          w_scan;
    logic [31:0]            w_pick_word;
    logic                   w_grant_go;
    logic                   w_done_ok;
    logic                   w_timeout;

    // Rotating priority: scan upward from the requester after the last one served.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            if (!w_pick_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == ID_W'(i)) begin
                w_pick_word = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found && eng_ready) begin
                    w_grant_go  = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done takes precedence over a watchdog expiring on the same cycle
                if (eng_done) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = RESPOND;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter is 0 in ISSUE and counts every cycle, so an abort lands TIMEOUT_CYCLES after ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= ID_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_crc   <= '0;
            r_rsp_error <= 1'b0;
            r_word      <= '0;
            r_issue     <= 1'b0;
            r_busy      <= 1'b0;
            r_grant     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_issue     <= 1'b0;
            r_busy      <= (w_state_nxt != IDLE);

            if (w_grant_go) begin
                r_cnt       <= '0;
                r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                r_issue     <= 1'b1;
                r_word      <= w_pick_word;
                r_grant     <= w_pick_idx;
            end else if (r_state == ISSUE || r_state == WAIT_DONE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_done_ok) begin
                r_rsp_crc   <= eng_crc_out;
                r_rsp_error <= 1'b0;
                r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
            end else if (w_timeout) begin
                r_rsp_crc   <= '0;
                r_rsp_error <= 1'b1;
                r_timeout   <= 1'b1;
                r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
            end

            if (r_state == RESPOND) begin
                r_last <= r_grant;
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_crc        = r_rsp_crc;
    assign rsp_error      = r_rsp_error;
    assign eng_data_in    = r_word;
    assign eng_start      = r_issue;
    assign eng_data_valid = r_issue;
    assign busy           = r_busy;
    assign grant_id       = r_grant;
    assign timeout_flag   = r_timeout;

endmodule

// File: tb/tb_crc32_arbiter.sv
// Bench for crc32_arbiter: engine stub, transaction-timeline model checked every cycle,
// and directed scenarios with literal CRC/grant expectations.
module tb_crc32_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TMO     = 64;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_crc;
    logic                  rsp_error;
    logic [31:0]           eng_data_in;
    logic                  eng_start;
    logic                  eng_data_valid;
    logic [31:0]           eng_crc_out;
    logic                  eng_done;
    logic                  eng_ready;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  timeout_flag;

    crc32_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_crc(rsp_crc),
        .rsp_error(rsp_error),
        .eng_data_in(eng_data_in),
        .eng_start(eng_start),
        .eng_data_valid(eng_data_valid),
        .eng_crc_out(eng_crc_out),
        .eng_done(eng_done),
        .eng_ready(eng_ready),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference CRC values of the engine for the words used here.
    function automatic logic [31:0] crc_of(input logic [31:0] w);
        case (w)
            32'h0000_0000: return 32'h2144_DF1C;
            32'h1234_5678: return 32'hAF6D_87D2;
            32'hDEAD_BEEF: return 32'h1A5A_601F;
            32'hAAAA_AAAA: return 32'hB596_E05E;
            32'h5555_5555: return 32'h6B2D_C0BD;
            default:       return {w[15:0], w[31:16]} ^ 32'h04C1_1DB7;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input int id);
        logic [3:0] v;
        v = 4'b0001 << id;
        return v;
    endfunction

    // Rotate the request vector so the slot after last sits at bit 0, take the lowest set bit.
    function automatic int rr_pick(input logic [3:0] rv, input int last);
        logic [7:0] dbl;
        logic [7:0] sh;
        dbl = {rv, rv};
        sh  = dbl >> (last + 1);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sh[j]) return (last + 1 + j) % NUM_REQ;
        end
        return 0;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    int          n = 0;
    bit          m_in_txn = 0;
    int          m_last = NUM_REQ - 1;
    int          m_gid = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_crc = '0;
    logic        m_err = 1'b0;
    logic        m_sticky = 1'b0;
    int          m_issue = -10;
    int          m_rsp = -1;
    logic        prev_done = 1'b0;
    logic [31:0] prev_crc = '0;

    always @(negedge clk) begin
        logic [3:0] exp_rr;
        logic [3:0] exp_rv;
        logic       exp_iss;
        n++;
        if (!rst_n) begin
            chk("reset_ctrl", 32'({busy, grant_id, req_ready, rsp_valid, rsp_error,
                                   eng_start, eng_data_valid, timeout_flag}), 32'h0);
            chk("reset_rsp_crc", rsp_crc, 32'h0);
            chk("reset_eng_data_in", eng_data_in, 32'h0);
            m_in_txn = 0;
            m_last   = NUM_REQ - 1;
            m_gid    = 0;
            m_word   = '0;
            m_crc    = '0;
            m_err    = 1'b0;
            m_sticky = 1'b0;
            m_issue  = -10;
            m_rsp    = -1;
        end else begin
            if (m_in_txn && m_rsp < 0) begin
                if (prev_done && (n - 1) > m_issue) begin
                    m_rsp = n;
                    m_crc = prev_crc;
                    m_err = 1'b0;
                end else if (n == m_issue + TMO) begin
                    m_rsp    = n;
                    m_crc    = '0;
                    m_err    = 1'b1;
                    m_sticky = 1'b1;
                end
            end
            exp_iss = m_in_txn && (n == m_issue);
            exp_rr  = exp_iss ? onehot(m_gid) : 4'b0000;
            exp_rv  = (m_in_txn && n == m_rsp) ? onehot(m_gid) : 4'b0000;
            chk("req_ready", 32'(req_ready), 32'(exp_rr));
            chk("eng_start", 32'(eng_start), 32'(exp_iss));
            chk("eng_data_valid", 32'(eng_data_valid), 32'(exp_iss));
            chk("eng_data_in", eng_data_in, m_word);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rsp_crc", rsp_crc, m_crc);
            chk("rsp_error", 32'(rsp_error), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_in_txn));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("timeout_flag", 32'(timeout_flag), 32'(m_sticky));
            if (m_in_txn) begin
                if (n == m_rsp) begin
                    m_in_txn = 0;
                    m_last   = m_gid;
                end
            end else if (req_valid != 4'b0000 && eng_ready) begin
                m_gid    = rr_pick(req_valid, m_last);
                m_word   = req_data[32*m_gid +: 32];
                m_in_txn = 1;
                m_issue  = n + 1;
                m_rsp    = -1;
            end
        end
        prev_done = eng_done;
        prev_crc  = eng_crc_out;
    end

    // ---------------- stimulus, requesters and engine stub ----------------
    logic [3:0]  hold;
    bit          stub_stuck;
    int          stub_lat;
    bit          stray;
    bit          st_busy;
    int          st_cnt;
    logic [31:0] st_word;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && !hold[i]) req_valid[i] = 1'b0;
        end
        if (!rst_n) begin
            st_busy     = 0;
            eng_done    = 1'b0;
            eng_crc_out = '0;
        end else begin
            eng_done    = 1'b0;
            eng_crc_out = ~st_word;
            if (stray) begin
                eng_done    = 1'b1;
                eng_crc_out = 32'h0BAD_0BAD;
                stray       = 0;
            end
            if (st_busy) begin
                if (st_cnt == 0) begin
                    eng_done    = 1'b1;
                    eng_crc_out = crc_of(st_word);
                    st_busy     = 0;
                end else begin
                    st_cnt--;
                end
            end
            if (eng_start && eng_data_valid && !stub_stuck) begin
                st_busy = 1;
                st_cnt  = stub_lat;
                st_word = eng_data_in;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        hold      = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string nm, input logic [3:0] exp_rr);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (req_ready == 4'b0000 && k < 50);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'(exp_rr));
    endtask

    task automatic wait_rsp(input string nm, input logic [3:0] exp_rv,
                            input logic [31:0] exp_crc, input logic exp_err, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (rsp_valid == 4'b0000 && k < 200);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_rv));
        chk({nm, "_rsp_crc"}, rsp_crc, exp_crc);
        chk({nm, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
    endtask

    logic [31:0] words [4] = '{32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'hAAAA_AAAA};
    logic [31:0] crcs  [4] = '{32'h2144_DF1C, 32'hAF6D_87D2, 32'h1A5A_601F, 32'hB596_E05E};
    int          alt   [4] = '{3, 1, 3, 1};

    initial begin
        int  k;
        bit  seen;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        hold        = '0;
        eng_ready   = 1'b1;
        eng_done    = 1'b0;
        eng_crc_out = '0;
        stub_stuck  = 0;
        stub_lat    = 2;
        stray       = 0;
        st_busy     = 0;
        st_cnt      = 0;
        st_word     = '0;

        // single request from requester 0
        apply_reset();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        req_data[31:0] = 32'h0000_0000;
        req_valid      = 4'b0001;
        wait_ready("t1", 4'b0001);
        chk("t1_eng_start", 32'(eng_start), 32'h1);
        chk("t1_eng_data_valid", 32'(eng_data_valid), 32'h1);
        step();
        chk("t1_start_1cycle", 32'(eng_start), 32'h0);
        wait_rsp("t1", 4'b0001, 32'h2144_DF1C, 1'b0, k);
        chk("t1_busy_in_respond", 32'(busy), 32'h1);
        step();
        chk("t1_busy_after", 32'(busy), 32'h0);

        // all four at once, fastest engine
        apply_reset();
        stub_lat = 0;
        for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = words[i];
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_ready("t2", onehot(i));
            wait_rsp("t2", onehot(i), crcs[i], 1'b0, k);
        end
        stub_lat = 2;

        // requesters 1 and 3 held continuously after 1 was served last
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = words[i];
        req_data[127:96] = 32'hAAAA_AAAA;
        req_valid = 4'b0010;
        wait_ready("t3_first", 4'b0010);
        wait_rsp("t3_first", 4'b0010, 32'hAF6D_87D2, 1'b0, k);
        hold      = 4'b1010;
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            wait_ready("t3_alt", onehot(alt[i]));
            wait_rsp("t3_alt", onehot(alt[i]), crcs[alt[i]], 1'b0, k);
        end
        hold      = '0;
        req_valid = '0;

        // engine never finishes, then recovers
        stub_stuck      = 1;
        req_data[95:64] = 32'h5555_5555;
        req_valid       = 4'b0100;
        wait_ready("t4_to", 4'b0100);
        wait_rsp("t4_to", 4'b0100, 32'h0, 1'b1, k);
        chk("t4_timeout_latency", 32'(k), 32'(TMO));
        chk("t4_timeout_flag", 32'(timeout_flag), 32'h1);
        stub_stuck = 0;
        req_valid  = 4'b0100;
        wait_ready("t4_ok", 4'b0100);
        wait_rsp("t4_ok", 4'b0100, 32'h6B2D_C0BD, 1'b0, k);
        chk("t4_flag_sticky", 32'(timeout_flag), 32'h1);

        // engine not ready: no grant until it is
        eng_ready = 1'b0;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_grant", 32'({busy, req_ready}), 32'h0);
        end
        eng_ready = 1'b1;
        step();
        chk("t5_grant_ready", 32'(req_ready), 32'(4'b0010));
        chk("t5_grant_id", 32'(grant_id), 32'h1);
        wait_rsp("t5", 4'b0010, 32'hAF6D_87D2, 1'b0, k);

        // stray done while idle is ignored
        stray = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_rsp", 32'({busy, rsp_valid}), 32'h0);
        end

        // asynchronous reset in the middle of WAIT_DONE
        stub_lat        = 20;
        req_data[95:64] = 32'hDEAD_BEEF;
        req_valid       = 4'b0100;
        wait_ready("t7_pre", 4'b0100);
        step();
        step();
        chk("t7_in_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_ctrl", 32'({busy, grant_id, req_ready, rsp_valid, rsp_error,
                                  eng_start, eng_data_valid, timeout_flag}), 32'h0);
        chk("t7_async_data", eng_data_in | rsp_crc, 32'h0);
        req_valid = '0;
        step();
        step();
        rst_n    = 1'b1;
        stub_lat = 2;
        seen     = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rsp_valid != 4'b0000) seen = 1;
        end
        chk("t7_abandoned_no_rsp", 32'(seen), 32'h0);
        req_data[31:0]   = 32'h0000_0000;
        req_data[127:96] = 32'hAAAA_AAAA;
        req_valid        = 4'b1001;
        wait_ready("t7_first", 4'b0001);
        wait_rsp("t7_first", 4'b0001, 32'h2144_DF1C, 1'b0, k);
        wait_ready("t7_second", 4'b1000);
        wait_rsp("t7_second", 4'b1000, 32'hB596_E05E, 1'b0, k);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
